uart_tx_framer: RTL

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer_if.sv | 11 +
 rtl/uart_tx_framer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/uart_tx_framer_if.sv
// Host-side frame handshake for uart_tx_framer: payload plus valid/ready.
interface uart_tx_framer_if #(
    parameter int DataBits = 8
);
    logic [DataBits-1:0] data;
    logic                valid;
    logic                ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DataBits payload, optional parity, StopBits stop bits.
// Bit timing comes entirely from the external baud_tick strobe.
module uart_tx_framer #(
    parameter int DataBits = 8,
    parameter int Parity   = 0,
    parameter int StopBits = 1,
    parameter bit MsbFirst = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    uart_tx_framer_if.slave   host,
    input  logic              baud_tick,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int BitCntW  = $clog2(DataBits + 1);
    localparam int StopCntW = $clog2(StopBits + 1);
    localparam logic [BitCntW-1:0]  LastBit   = BitCntW'(DataBits - 1);
    localparam logic [StopCntW-1:0] LastStop  = StopCntW'(StopBits - 1);
    localparam bit                  HasParity = (Parity != 0);
    localparam bit                  OddParity = (Parity == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_reg, state_next;
    logic [DataBits-1:0]   shift_reg, shift_next, shift_step;
    logic [BitCntW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [StopCntW-1:0]   stop_cnt_reg, stop_cnt_next;
    logic                  parity_reg, parity_next;
    logic                  tx_reg, tx_next;
    logic                  done_reg, done_next;
    logic                  ready_int;
    logic                  accept;

    assign ready_int  = (state_reg == IDLE);
    assign accept     = host.valid && ready_int;
    assign host.ready = ready_int;
    assign busy       = !ready_int;
    assign tx         = tx_reg;
    assign done       = done_reg;

    // One-position shift toward the outgoing end, zero-filling the vacated bit.
    generate
        for (genvar gi = 0; gi < DataBits; gi++) begin : g_shift
            if (MsbFirst) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shift_step[gi] = 1'b0;
                end else begin : g_move
                    assign shift_step[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == DataBits - 1) begin : g_fill
                    assign shift_step[gi] = 1'b0;
                end else begin : g_move
                    assign shift_step[gi] = shift_reg[gi+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (accept) state_next = START;
            START:  if (baud_tick) state_next = DATA;
            DATA:   if (baud_tick && (bit_cnt_reg == LastBit))
                        state_next = HasParity ? PARITY : STOP;
            PARITY: if (baud_tick) state_next = STOP;
            STOP:   if (baud_tick && (stop_cnt_reg == LastStop)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Parity is fixed at acceptance, so bit order never affects it.
    always_comb begin
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        parity_next   = parity_reg;
        if (accept) begin
            shift_next    = host.data;
            bit_cnt_next  = '0;
            stop_cnt_next = '0;
            parity_next   = (^host.data) ^ OddParity;
        end else if (baud_tick) begin
            if (state_reg == DATA) begin
                shift_next   = shift_step;
                bit_cnt_next = bit_cnt_reg + 1'b1;
            end
            if (state_reg == STOP) begin
                stop_cnt_next = stop_cnt_reg + 1'b1;
            end
        end
    end

    // tx is decoded from the upcoming state so the line switches on the same edge as the FSM.
    always_comb begin
        tx_next   = 1'b1;
        done_next = (state_reg == STOP) && (state_next == IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = MsbFirst ? shift_next[DataBits-1] : shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= '0;
            parity_reg   <= 1'b0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            parity_reg   <= parity_next;
            tx_reg       <= tx_next;
            done_reg     <= done_next;
        end
    end
endmodule
